// File: rtl/mem_port_arbiter.sv
// Shares one single-port main memory between the fetch port (read-only) and the data port (load/store).
// Data wins by default; a saturating counter forces a fetch grant after STARVE_LIMIT data wins in a row.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] ADDR_RESET   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    output logic        instr_ack,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic [3:0]  starve_cnt_q;
    logic        owner_live_q;
    logic        busy_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        instr_ack_q;
    logic        data_ack_q;
    logic [31:0] instr_rdata_q;
    logic [31:0] data_rdata_q;

    logic        grant_data;
    logic        grant_instr;
    logic [3:0]  starve_inc;

    always_comb begin
        grant_data  = 1'b0;
        grant_instr = 1'b0;
        if (data_req && (!instr_req || (LIMIT == 4'd0) || (starve_cnt_q < LIMIT))) begin
            grant_data = 1'b1;
        end else if (instr_req) begin
            grant_instr = 1'b1;
        end
    end

    assign starve_inc = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;

    // owner_live_q drops for good once the owner withdraws; the bus access still runs to completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= 4'd0;
            owner_live_q  <= 1'b0;
            busy_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wstrb_q   <= 4'd0;
            mem_addr_q    <= ADDR_RESET;
            mem_wdata_q   <= 32'd0;
            instr_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            instr_rdata_q <= 32'd0;
            data_rdata_q  <= 32'd0;
        end else begin
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        state_q      <= MEM_D;
                        busy_q       <= 1'b1;
                        owner_live_q <= 1'b1;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= data_we;
                        mem_wstrb_q  <= data_we ? data_wstrb : 4'd0;
                        mem_addr_q   <= data_addr;
                        mem_wdata_q  <= data_wdata;
                        starve_cnt_q <= instr_req ? starve_inc : 4'd0;
                    end else if (grant_instr) begin
                        state_q      <= MEM_I;
                        busy_q       <= 1'b1;
                        owner_live_q <= 1'b1;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_wstrb_q  <= 4'd0;
                        mem_addr_q   <= instr_addr;
                        mem_wdata_q  <= 32'd0;
                        starve_cnt_q <= 4'd0;
                    end else begin
                        starve_cnt_q <= 4'd0;
                    end
                end
                MEM_I: begin
                    if (!instr_req) begin
                        owner_live_q <= 1'b0;
                    end
                    if (mem_ack) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (owner_live_q && instr_req) begin
                            instr_rdata_q <= mem_rdata;
                            instr_ack_q   <= 1'b1;
                        end
                    end
                end
                MEM_D: begin
                    if (!data_req) begin
                        owner_live_q <= 1'b0;
                    end
                    if (mem_ack) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (owner_live_q && data_req) begin
                            data_rdata_q <= mem_rdata;
                            data_ack_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    owner_live_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instr_ack   = instr_ack_q;
    assign data_ack    = data_ack_q;
    assign instr_rdata = instr_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized two-requester traffic,
// with a latency-configurable memory responder and a rule-based arbitration reference.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam logic [31:0] ARST  = 32'h0000_0F00;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        ireq;
        logic        dreq;
    } grant_t;

    logic        clk, rst;
    logic        instr_req, instr_ack;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_ack;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_RESET(ARST)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_ack(instr_ack),
        .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [7:0] i);
        if (i == 8'h40) return 32'h00A00093;
        if (i == 8'hC0) return 32'h12345678;
        return {8'hC3, i, ~i, i ^ 8'h5A};
    endfunction

    // Memory responder: acks each request after mem_lat (or random 0..3) extra cycles.
    logic [31:0] mem_arr [0:255];
    int mem_lat = 0;
    bit lat_rand = 1'b0;
    int stray_seq = 0;

    initial begin : memory
        int cnt, lat, seen_stray;
        bit done, started;
        logic [7:0] idx;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) mem_arr[i] = init_word(8'(i));
        mem_ack = 1'b0; mem_rdata = 32'd0;
        cnt = 0; lat = 0; seen_stray = 0; done = 1'b0; started = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (stray_seq != seen_stray) begin
                seen_stray = stray_seq;
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else if (mem_req && !done) begin
                if (!started) begin
                    started = 1'b1; cnt = 0;
                    lat = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (cnt >= lat) begin
                    idx = mem_addr[9:2];
                    w = mem_arr[idx];
                    mem_rdata = w;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_arr[idx] = w;
                    end
                    mem_ack = 1'b1;
                    done = 1'b1;
                end else begin
                    cnt++;
                end
            end else if (!mem_req) begin
                done = 1'b0; started = 1'b0;
            end
        end
    end

    // Monitor: logs every grant (rising mem_req) with the requests seen at that edge.
    grant_t grants[$];
    int iack_cnt = 0, dack_cnt = 0, both_cnt = 0, unstable_cnt = 0;

    initial begin : monitor
        logic ireq_s, dreq_s, prev_req;
        grant_t cur, prev;
        ireq_s = 1'b0; dreq_s = 1'b0; prev_req = 1'b0; prev = '0;
        forever begin
            @(posedge clk);
            ireq_s = instr_req; dreq_s = data_req;
            @(negedge clk);
            if (instr_ack && data_ack) both_cnt++;
            if (instr_ack) iack_cnt++;
            if (data_ack) dack_cnt++;
            cur.addr = mem_addr; cur.we = mem_we; cur.wstrb = mem_wstrb; cur.wdata = mem_wdata;
            cur.ireq = ireq_s; cur.dreq = dreq_s;
            if (mem_req && prev_req &&
                ({cur.addr, cur.we, cur.wstrb, cur.wdata} != {prev.addr, prev.we, prev.wstrb, prev.wdata}))
                unstable_cnt++;
            if (mem_req && !prev_req) grants.push_back(cur);
            prev_req = mem_req;
            prev = cur;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, required the bench to finish first");
        $fatal(1);
    end

    function automatic grant_t get_grant(input int i);
        grant_t g;
        g = '0;
        if (i < grants.size()) g = grants[i];
        return g;
    endfunction

    logic [31:0] ref_mem [0:255];
    logic [31:0] last_ird_exp = 32'd0;

    task automatic instr_txn(input logic [31:0] addr, output int cyc);
        bit got;
        logic [31:0] rd;
        instr_addr = addr; instr_req = 1'b1; cyc = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk); cyc++;
            if (instr_ack) got = 1'b1;
        end
        check("iack_seen", 32'(got), 32'd1);
        rd = instr_rdata;
        check("fetch_data", rd, init_word(addr[9:2]));
        check("iack_excl", 32'(data_ack), 32'd0);
        last_ird_exp = init_word(addr[9:2]);
        @(posedge clk); #1;
        instr_req = 1'b0;
        @(negedge clk);
        check("iack_pulse", 32'(instr_ack), 32'd0);
    endtask

    task automatic data_txn(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        bit got;
        logic [7:0] idx;
        data_we = we; data_wstrb = strb; data_addr = addr; data_wdata = wd; data_req = 1'b1;
        cyc = 0; got = 1'b0; idx = addr[9:2];
        while (!got && cyc < 60) begin
            @(negedge clk); cyc++;
            if (data_ack) got = 1'b1;
        end
        check("dack_seen", 32'(got), 32'd1);
        rd = data_rdata;
        check("dack_excl", 32'(instr_ack), 32'd0);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            check("load_data", rd, ref_mem[idx]);
        end
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        check("dack_pulse", 32'(data_ack), 32'd0);
    endtask

    initial begin : main
        int cyc, icyc, dcyc, gs, n0, run, got_req;
        logic [31:0] rd;
        grant_t g;
        bit exp_d;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        rst = 1'b1;
        instr_req = 1'b0; instr_addr = 32'd0;
        data_req = 1'b0; data_we = 1'b0; data_wstrb = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, ARST);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_acks", {30'd0, instr_ack, data_ack}, 32'd0);
        check("rst_instr_rdata", instr_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch, memory acks two cycles after mem_req rises
        mem_lat = 2;
        gs = grants.size(); n0 = dack_cnt;
        instr_txn(32'h0000_0100, cyc);
        check("fetch_lat", 32'(cyc), 32'd5);
        check("fetch_rdata", instr_rdata, 32'h00A00093);
        g = get_grant(gs);
        check("fetch_addr", g.addr, 32'h0000_0100);
        check("fetch_we", 32'(g.we), 32'd0);
        check("fetch_no_dack", 32'(dack_cnt - n0), 32'd0);

        // Load with strobes ignored, zero-wait memory
        mem_lat = 0;
        gs = grants.size();
        @(posedge clk); #1;
        data_txn(1'b0, 4'h3, 32'h0000_0300, 32'hFFFF_FFFF, rd, cyc);
        check("load_rdata", rd, 32'h12345678);
        check("load_lat", 32'(cyc), 32'd3);
        g = get_grant(gs);
        check("load_we", 32'(g.we), 32'd0);
        check("load_wstrb", 32'(g.wstrb), 32'd0);

        // Simultaneous requests: data first, then instr
        mem_lat = 1;
        gs = grants.size();
        @(posedge clk); #1;
        fork
            instr_txn(32'h0000_0104, icyc);
            data_txn(1'b1, 4'hF, 32'h0000_0200, 32'hDEADBEEF, rd, dcyc);
        join
        check("sim_ngrants", 32'(grants.size() - gs), 32'd2);
        g = get_grant(gs);
        check("sim_g0_addr", g.addr, 32'h0000_0200);
        check("sim_g0_we", 32'(g.we), 32'd1);
        check("sim_g0_wstrb", 32'(g.wstrb), 32'hF);
        check("sim_g0_wdata", g.wdata, 32'hDEADBEEF);
        g = get_grant(gs + 1);
        check("sim_g1_addr", g.addr, 32'h0000_0104);
        check("sim_ack_order", 32'(dcyc < icyc), 32'd1);

        // Starvation: both held, expect DDDDI repeating
        mem_lat = 0;
        gs = grants.size();
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 3; k++) instr_txn(32'h0000_0010 + 32'(k) * 4, icyc);
            end
            begin
                logic [31:0] rdb;
                int cb;
                for (int m = 0; m < 12; m++)
                    data_txn(1'(m & 1), 4'(m), 32'h0000_0280 + 32'(m) * 4, $urandom, rdb, cb);
            end
        join
        check("starve_ngrants", 32'(grants.size() - gs), 32'd15);
        for (int k = 0; k < 15; k++) begin
            g = get_grant(gs + k);
            check($sformatf("starve_seq[%0d]", k), 32'(g.addr[9]), 32'((k % 5) != 4));
        end

        // Withdrawal: fetch drops req mid-access, pending data is then served
        mem_lat = 3;
        gs = grants.size(); n0 = iack_cnt;
        @(posedge clk); #1;
        instr_addr = 32'h0000_0040; instr_req = 1'b1;
        @(negedge clk); @(negedge clk);
        check("wd_grant_req", 32'(mem_req), 32'd1);
        check("wd_grant_addr", mem_addr, 32'h0000_0040);
        @(posedge clk); #1;
        instr_req = 1'b0; instr_addr = 32'h0000_0ABC;
        data_txn(1'b0, 4'h0, 32'h0000_0204, 32'd0, rd, dcyc);
        check("wd_data_lat", 32'(dcyc), 32'd10);
        check("wd_no_iack", 32'(iack_cnt - n0), 32'd0);
        check("wd_irdata_held", instr_rdata, last_ird_exp);
        g = get_grant(gs + 1);
        check("wd_next_grant", g.addr, 32'h0000_0204);

        // Reset in the middle of a data access
        mem_lat = 5;
        @(posedge clk); #1;
        data_we = 1'b1; data_wstrb = 4'hF; data_addr = 32'h0000_0208; data_wdata = 32'h55AA55AA;
        data_req = 1'b1;
        got_req = 0;
        for (int k = 0; k < 10 && got_req == 0; k++) begin
            @(negedge clk);
            if (mem_req) got_req = 1;
        end
        check("rm_req_before", 32'(got_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rm_mem_req", 32'(mem_req), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_mem_addr", mem_addr, ARST);
        check("rm_mem_we", 32'(mem_we), 32'd0);
        check("rm_data_rdata", data_rdata, 32'd0);
        check("rm_instr_rdata", instr_rdata, 32'd0);
        check("rm_acks", {30'd0, instr_ack, data_ack}, 32'd0);
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n0 = iack_cnt + dack_cnt;
        #2 stray_seq = stray_seq + 1;
        repeat (4) @(negedge clk);
        check("rm_stray_acks", 32'(iack_cnt + dack_cnt - n0), 32'd0);
        check("rm_stray_req", 32'(mem_req), 32'd0);
        check("rm_stray_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        instr_txn(32'h0000_0020, cyc);

        // Randomized traffic with random memory latency
        lat_rand = 1'b1;
        gs = grants.size();
        @(posedge clk); #1;
        fork
            begin
                int ci;
                for (int a = 0; a < 20; a++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    instr_txn(32'($urandom_range(0, 127)) << 2, ci);
                end
            end
            begin
                int cd;
                logic [31:0] rdr;
                for (int a = 0; a < 20; a++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    data_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                             32'($urandom_range(128, 255)) << 2, $urandom, rdr, cd);
                end
            end
        join
        check("rnd_ngrants", 32'(grants.size() - gs), 32'd40);
        run = 0;
        for (int k = gs; k < grants.size(); k++) begin
            g = grants[k];
            exp_d = g.dreq && (!g.ireq || LIMIT == 0 || run < int'(LIMIT));
            check("rnd_arb", 32'(g.addr[9]), 32'(exp_d));
            if (!g.addr[9]) check("rnd_instr_we", 32'(g.we), 32'd0);
            if (!g.we) check("rnd_load_wstrb", 32'(g.wstrb), 32'd0);
            run = (g.addr[9] && g.ireq) ? run + 1 : 0;
        end

        check("ack_exclusive", 32'(both_cnt), 32'd0);
        check("bus_stable", 32'(unstable_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
